riscv_uart_programmer: RTL and testbench

RISCV_UART_PROGRAMMER -- requirements
Module: riscv_uart_programmer

---
 rtl/riscv_uart_programmer_pkg.sv | 29 ++
 rtl/riscv_uart_rx.sv | 99 +++++++++
 rtl/riscv_uart_programmer.sv | 165 ++++++++++++++++
 tb/tb_riscv_uart_programmer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_uart_programmer_pkg.sv
// Purpose: shared definitions for the UART boot-image programmer (address width, FSM encodings).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Build option: UPG_CHECKSUM_EN adds the ST_CHECK encoding used by the checksum feature.
package riscv_uart_programmer_pkg;

    localparam int UPG_ADDR_W = 14;

    // Image loader states. ST_CHECK exists only when the checksum feature is built in.
    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UPG_CHECKSUM_EN
        ST_CHECK  = 3'd3,
`endif
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } load_state_t;

    // Byte receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/riscv_uart_rx.sv
// Purpose: 8N1 UART byte receiver with two-flop input synchronizer and start-bit glitch rejection.
// Latency: byte_valid/frame_err pulse one cycle after the stop-bit sample (~9.5 bit times after start edge).
// Backpressure: none; the consumer must accept each one-cycle pulse.
// Ports: clk, rst (sync, active-high), rx (async line, idle high);
//        rx_byte[7:0] (holds last good byte), byte_valid (1-cycle), frame_err (1-cycle, stop bit was 0).
module riscv_uart_rx
    import riscv_uart_programmer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer resets to the idle level so reset release never looks like a start edge.
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check the line at mid start bit; a high line here was a glitch.
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};   // LSB arrives first
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/riscv_uart_programmer.sv
// Purpose: loads a length-prefixed word image from a UART line into instruction/data memory.
// Latency: upg_wen_o pulses one cycle after the 4th byte of each word is received.
// Backpressure: none; the memory must accept a write on every upg_wen_o pulse.
// Ports: clk, rst (sync, active-high), rx (async UART, idle high);
//        upg_wen_o (1-cycle write strobe), upg_adr_o[13:0] word address, upg_dat_o[31:0] write data,
//        upg_done_o (image loaded, level), upg_err_o (framing/checksum failure, level).
// Build option: define UPG_CHECKSUM_EN to require a trailing XOR checksum byte over length and data.
module riscv_uart_programmer
    import riscv_uart_programmer_pkg::*;
#(
    parameter int CLK_FREQ = 10000000,
    parameter int BAUD     = 115200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  upg_wen_o,
    output logic [UPG_ADDR_W-1:0] upg_adr_o,
    output logic [31:0]           upg_dat_o,
    output logic                  upg_done_o,
    output logic                  upg_err_o
);

    localparam int DIV = CLK_FREQ / BAUD;

    logic [7:0]            rx_byte;
    logic                  byte_valid;
    logic                  frame_err;

    load_state_t           state;
    logic [7:0]            len_lo;
    logic [UPG_ADDR_W-1:0] len;
    logic [UPG_ADDR_W-1:0] wcnt;
    logic [1:0]            byte_idx;
    logic [23:0]           lane;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    riscv_uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LEN_LO;
            len_lo     <= '0;
            len        <= '0;
            wcnt       <= '0;
            byte_idx   <= '0;
            lane       <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            upg_wen_o <= 1'b0;
            // Address advances right after each write so it stays stable during the strobe.
            if (upg_wen_o) begin
                upg_adr_o <= upg_adr_o + UPG_ADDR_W'(1);
            end

            case (state)
                ST_LEN_LO: begin
                    if (frame_err) begin
                        state     <= ST_ERR;
                        upg_err_o <= 1'b1;
                    end else if (byte_valid) begin
                        len_lo <= rx_byte;
`ifdef UPG_CHECKSUM_EN
                        csum   <= csum ^ rx_byte;
`endif
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (frame_err) begin
                        state     <= ST_ERR;
                        upg_err_o <= 1'b1;
                    end else if (byte_valid) begin
                        // Top two bits of the high length byte are outside the 14-bit word space.
                        len <= {rx_byte[5:0], len_lo};
`ifdef UPG_CHECKSUM_EN
                        csum <= csum ^ rx_byte;
`endif
                        if ({rx_byte[5:0], len_lo} == '0) begin
`ifdef UPG_CHECKSUM_EN
                            state      <= ST_CHECK;
`else
                            state      <= ST_DONE;
                            upg_done_o <= 1'b1;
`endif
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (frame_err) begin
                        state     <= ST_ERR;
                        upg_err_o <= 1'b1;
                    end else if (byte_valid) begin
`ifdef UPG_CHECKSUM_EN
                        csum     <= csum ^ rx_byte;
`endif
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: lane[7:0]   <= rx_byte;
                            2'd1: lane[15:8]  <= rx_byte;
                            2'd2: lane[23:16] <= rx_byte;
                            default: begin
                                upg_dat_o <= {rx_byte, lane};
                                upg_wen_o <= 1'b1;
                                wcnt      <= wcnt + UPG_ADDR_W'(1);
                                if (wcnt + UPG_ADDR_W'(1) == len) begin
`ifdef UPG_CHECKSUM_EN
                                    state      <= ST_CHECK;
`else
                                    state      <= ST_DONE;
                                    upg_done_o <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef UPG_CHECKSUM_EN
                ST_CHECK: begin
                    if (frame_err) begin
                        state     <= ST_ERR;
                        upg_err_o <= 1'b1;
                    end else if (byte_valid) begin
                        if (rx_byte == csum) begin
                            state      <= ST_DONE;
                            upg_done_o <= 1'b1;
                        end else begin
                            state     <= ST_ERR;
                            upg_err_o <= 1'b1;
                        end
                    end
                end
`endif
                // DONE and ERR hold until reset; incoming bytes are ignored.
                ST_DONE: state <= ST_DONE;
                ST_ERR:  state <= ST_ERR;
                default: begin
                    state     <= ST_ERR;
                    upg_err_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_uart_programmer.sv
// Purpose: self-checking bench for riscv_uart_programmer (directed cases plus randomized images).
// Latency: n/a.
// Backpressure: n/a.
module tb_riscv_uart_programmer;

    localparam int CLK_FREQ = 40;
    localparam int BAUD     = 10;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UPG_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        upg_wen_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        upg_err_o;

    always #5 clk = ~clk;

    riscv_uart_programmer #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .upg_err_o  (upg_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Observed writes and protocol violations, collected on the falling edge.
    logic [13:0] got_adr[$];
    logic [31:0] got_dat[$];
    int          viol_wide = 0;
    int          viol_both = 0;
    logic        prev_wen  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (upg_wen_o) begin
                got_adr.push_back(upg_adr_o);
                got_dat.push_back(upg_dat_o);
                if (prev_wen) viol_wide++;
            end
            if (upg_done_o && upg_err_o) viol_both++;
        end
        prev_wen = upg_wen_o;
    end

    // Stimulus stream: byte values and whether each byte gets a bad stop bit.
    logic [7:0]  stim_b[$];
    bit          stim_f[$];

    logic [13:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic        exp_done;
    logic        exp_err;

    task automatic add(input logic [7:0] b, input bit bad_stop);
        stim_b.push_back(b);
        stim_f.push_back(bad_stop);
    endtask

    function automatic logic [7:0] xor_all();
        logic [7:0] x = 8'h00;
        foreach (stim_b[i]) x ^= stim_b[i];
        return x;
    endfunction

    task automatic clear_capture();
        got_adr.delete();
        got_dat.delete();
        viol_wide = 0;
        viol_both = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_capture();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic send_stream();
        foreach (stim_b[i]) send_byte(stim_b[i], stim_f[i]);
        repeat (6 * DIV) @(negedge clk);
    endtask

    // Reference: image = len_lo, len_hi, N little-endian words, optional XOR byte.
    task automatic build_expected();
        int         n;
        int         term;
        logic [7:0] x;
        exp_adr.delete();
        exp_dat.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n    = int'(stim_b[1][5:0]) * 256 + int'(stim_b[0]);
        term = 2 + 4 * n + CSUM;
        for (int i = 0; i < term; i++) begin
            if (stim_f[i]) begin
                exp_err = 1'b1;
                return;
            end
            if (i >= 2 && i < 2 + 4 * n && (i - 2) % 4 == 3) begin
                exp_adr.push_back(14'((i - 2) / 4));
                exp_dat.push_back({stim_b[i], stim_b[i-1], stim_b[i-2], stim_b[i-3]});
            end
        end
        if (CSUM != 0) begin
            x = 8'h00;
            for (int i = 0; i < term - 1; i++) x ^= stim_b[i];
            if (x == stim_b[term-1]) exp_done = 1'b1;
            else                     exp_err  = 1'b1;
        end else begin
            exp_done = 1'b1;
        end
    endtask

    task automatic compare(input string tag);
        build_expected();
        check({tag, "_nwen"}, 32'(got_adr.size()), 32'(exp_adr.size()));
        foreach (exp_adr[i]) begin
            if (i < got_adr.size()) begin
                check($sformatf("%s_adr%0d", tag, i), 32'(got_adr[i]), 32'(exp_adr[i]));
                check($sformatf("%s_dat%0d", tag, i), got_dat[i], exp_dat[i]);
            end
        end
        check({tag, "_done"}, 32'(upg_done_o), 32'(exp_done));
        check({tag, "_err"},  32'(upg_err_o),  32'(exp_err));
        check({tag, "_wen_width"}, 32'(viol_wide), 32'd0);
        check({tag, "_done_err_both"}, 32'(viol_both), 32'd0);
    endtask

    task automatic load_base();
        stim_b.delete();
        stim_f.delete();
        add(8'h02, 0); add(8'h00, 0);
        add(8'h44, 0); add(8'h33, 0); add(8'h22, 0); add(8'h11, 0);
        add(8'hEF, 0); add(8'hBE, 0); add(8'hAD, 0); add(8'hDE, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wen"},  32'(upg_wen_o),  32'd0);
        check({tag, "_adr"},  32'(upg_adr_o),  32'd0);
        check({tag, "_dat"},  upg_dat_o,       32'd0);
        check({tag, "_done"}, 32'(upg_done_o), 32'd0);
        check({tag, "_err"},  32'(upg_err_o),  32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");

        // Two-word image
        do_reset();
        load_base();
        if (CSUM != 0) add(8'h64, 0);
        send_stream();
        compare("two_words");
        if (got_dat.size() >= 2) begin
            check("two_words_w0", got_dat[0], 32'h11223344);
            check("two_words_w1", got_dat[1], 32'hDEADBEEF);
        end

        // Empty image
        do_reset();
        stim_b.delete(); stim_f.delete();
        add(8'h00, 0); add(8'h00, 0);
        if (CSUM != 0) add(8'h00, 0);
        send_stream();
        compare("empty");

        // Framing error on the third byte
        do_reset();
        load_base();
        stim_f[2] = 1'b1;
        if (CSUM != 0) add(8'h64, 0);
        send_stream();
        compare("frame_err");

        // Bad checksum
        if (CSUM != 0) begin
            do_reset();
            load_base();
            add(8'h65, 0);
            send_stream();
            compare("bad_csum");
        end

        // Reset in the middle of an image, then a full image
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h44, 0);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_capture();
        load_base();
        if (CSUM != 0) add(8'h64, 0);
        send_stream();
        compare("after_rst");

        // One-cycle low glitch while idle must not produce a byte
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (6 * DIV) @(negedge clk);
        check("glitch_done", 32'(upg_done_o), 32'd0);
        check("glitch_err",  32'(upg_err_o),  32'd0);
        stim_b.delete(); stim_f.delete();
        add(8'h00, 0); add(8'h00, 0);
        if (CSUM != 0) add(8'h00, 0);
        send_stream();
        compare("glitch_then_empty");

        // Randomized images: small N, junk in len_hi[7:6], optional framing error,
        // optional bad checksum, trailing bytes that must be ignored.
        for (int it = 0; it < 12; it++) begin
            int n;
            int total;
            do_reset();
            stim_b.delete(); stim_f.delete();
            n = $urandom_range(0, 3);
            add(8'(n), 0);
            add({2'($urandom_range(0, 3)), 6'b0}, 0);
            for (int k = 0; k < 4 * n; k++) add(8'($urandom_range(0, 255)), 0);
            if (CSUM != 0) begin
                if ($urandom_range(0, 3) == 0) add(xor_all() ^ 8'($urandom_range(1, 255)), 0);
                else                           add(xor_all(), 0);
            end
            total = stim_b.size();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) add(8'($urandom_range(0, 255)), 0);
            if ($urandom_range(0, 9) < 4) stim_f[$urandom_range(0, total - 1)] = 1'b1;
            send_stream();
            compare($sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
